// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state type and default widths for the multiply-accumulate unit
// and its companion divider.
package mac_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/mac_shift_add_step.sv
// mac_shift_add_step: one shift-add iteration; conditionally adds the multiplicand
// and advances both shift registers.
module mac_shift_add_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [2*WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0]   mplier_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [2*WIDTH-1:0] mcand_o,
   output logic [WIDTH-1:0]   mplier_o
);
   assign acc_o    = mplier_i[0] ? acc_i + mcand_i : acc_i;
   assign mcand_o  = mcand_i << 1;
   assign mplier_o = mplier_i >> 1;
endmodule

// File: rtl/multiply_accumulate_8bit.sv
// multiply_accumulate_8bit: sequential shift-add unit computing a*b + c with start/done handshake.
// Optional MAC_RANGE_CHECK_EN adds err flag for b==0 or c>=b (illegal divider remainder).
module multiply_accumulate_8bit
   import mac_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [WIDTH-1:0]   c_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               err_o
);
   localparam int RW = 2*WIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);
   state_t           state_q;
   logic [RW-1:0]    acc_q, acc_d, mcand_q, mcand_d, result_q;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q;
   mac_shift_add_step #(.WIDTH(WIDTH)) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .mplier_i(mplier_q),
      .acc_o   (acc_d),
      .mcand_o (mcand_d),
      .mplier_o(mplier_d)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  acc_q    <= {{WIDTH{1'b0}}, c_i};
                  mcand_q  <= {{WIDTH{1'b0}}, a_i};
                  mplier_q <= b_i;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               result_q <= acc_q;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
`ifdef MAC_RANGE_CHECK_EN
   // b and c are kept unshifted so the range check sees the accepted operands.
   logic [WIDTH-1:0] b_q, c_q;
   logic             err_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         b_q   <= '0;
         c_q   <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == IDLE && start_i) begin
            b_q <= b_i;
            c_q <= c_i;
         end
         if (state_q == DONE) err_q <= (b_q == '0) || (c_q >= b_q);
      end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif
endmodule
